// File: rtl/core_status_monitor_if.sv
// core_status_monitor_if: status stream from the core plus the run summary returned by the monitor.
//   i_start / i_status / i_status_valid : driven by the core-side master
//   o_r_cnt, o_i_cnt, o_cycle_cnt       : run counters (CNT_W bits)
//   o_busy, o_done, o_result, o_proto_err : run state, terminal cause, sticky protocol error
interface core_status_monitor_if #(
    parameter int CNT_W = 16
);
    logic             i_start;
    logic [1:0]       i_status;
    logic             i_status_valid;
    logic [CNT_W-1:0] o_r_cnt;
    logic [CNT_W-1:0] o_i_cnt;
    logic [CNT_W-1:0] o_cycle_cnt;
    logic             o_busy;
    logic             o_done;
    logic [1:0]       o_result;
    logic             o_proto_err;

    modport master (
        output i_start, i_status, i_status_valid,
        input  o_r_cnt, o_i_cnt, o_cycle_cnt, o_busy, o_done, o_result, o_proto_err
    );

    modport slave (
        input  i_start, i_status, i_status_valid,
        output o_r_cnt, o_i_cnt, o_cycle_cnt, o_busy, o_done, o_result, o_proto_err
    );
endinterface

// File: rtl/core_status_monitor.sv
// core_status_monitor: tracks one program run of the core (R/I retirements, END/OVERFLOW, watchdog timeout).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : status stream in, registered run summary out
// Optional macro CORE_STATUS_MON_CYCLE_EN builds the RUN cycle counter; otherwise o_cycle_cnt is 0.
module core_status_monitor #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    core_status_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_END  = 2'd1;
    localparam logic [1:0] RES_OVF  = 2'd2;
    localparam logic [1:0] RES_TO   = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] r_q, r_d, i_q, i_d, gap_q, gap_d;
    logic [1:0]       res_q, res_d;
    logic             err_q, err_d, busy_q, done_q;
    logic             start, vld, expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    assign start  = bus.i_start;
    // i_start swallows a coincident valid: no count, no error
    assign vld    = bus.i_status_valid && !start;
    // a valid on the expiry cycle wins, so expiry only fires on a silent cycle
    assign expire = (state_q == RUN) && !bus.i_status_valid && (gap_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = start ? RUN
                : (state_q == RUN && ((vld && bus.i_status[1]) || expire)) ? DONE
                : state_q;
    end

    always_comb begin
        r_d   = r_q;
        i_d   = i_q;
        gap_d = gap_q;
        res_d = res_q;
        err_d = err_q;
        if (start) begin
            r_d   = '0;
            i_d   = '0;
            gap_d = '0;
            res_d = RES_NONE;
            err_d = 1'b0;
        end else if (state_q == RUN) begin
            gap_d = vld ? '0 : sat_inc(gap_q);
            r_d   = (vld && bus.i_status == 2'd0) ? sat_inc(r_q) : r_q;
            i_d   = (vld && bus.i_status == 2'd1) ? sat_inc(i_q) : i_q;
            res_d = expire                         ? RES_TO
                  : (vld && bus.i_status == 2'd2) ? RES_OVF
                  : (vld && bus.i_status == 2'd3) ? RES_END
                  : res_q;
        end else begin
            err_d = err_q | bus.i_status_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= '0;
            i_q    <= '0;
            gap_q  <= '0;
            res_q  <= RES_NONE;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            i_q    <= i_d;
            gap_q  <= gap_d;
            res_q  <= res_d;
            err_q  <= err_d;
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
        end
    end

`ifdef CORE_STATUS_MON_CYCLE_EN
    logic [CNT_W-1:0] cyc_q;

    // counts every RUN cycle, including the one that exits to DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)             cyc_q <= '0;
        else if (start)           cyc_q <= '0;
        else if (state_q == RUN)  cyc_q <= sat_inc(cyc_q);
    end

    assign bus.o_cycle_cnt = cyc_q;
`else
    assign bus.o_cycle_cnt = '0;
`endif

    assign bus.o_r_cnt     = r_q;
    assign bus.o_i_cnt     = i_q;
    assign bus.o_result    = res_q;
    assign bus.o_proto_err = err_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_core_status_monitor.sv
// tb_core_status_monitor: directed-vector bench for core_status_monitor (CNT_W=4, TIMEOUT_CYCLES=8).
module tb_core_status_monitor;
    localparam int CNT_W = 4;
    localparam int TO    = 8;
`ifdef CORE_STATUS_MON_CYCLE_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    core_status_monitor_if #(.CNT_W(CNT_W)) bus();

    core_status_monitor #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic int cyc_exp(input int n);
        return CYC_EN ? ((n > 15) ? 15 : n) : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string t, input int r, input int i, input int b,
                              input int d, input int res, input int e);
        check({t, ".r_cnt"}, 32'(bus.o_r_cnt), r);
        check({t, ".i_cnt"}, 32'(bus.o_i_cnt), i);
        check({t, ".busy"}, 32'(bus.o_busy), b);
        check({t, ".done"}, 32'(bus.o_done), d);
        check({t, ".result"}, 32'(bus.o_result), res);
        check({t, ".proto_err"}, 32'(bus.o_proto_err), e);
    endtask

    // apply inputs just after a falling edge; return at the next falling edge with outputs settled
    task automatic drive(input logic s, input logic v, input logic [1:0] st);
        bus.i_start        = s;
        bus.i_status_valid = v;
        bus.i_status       = st;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [1:0] sts [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3};
        bus.i_start        = 1'b0;
        bus.i_status_valid = 1'b0;
        bus.i_status       = 2'd0;
        repeat (3) @(negedge i_clk);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        check("reset.cycle", 32'(bus.o_cycle_cnt), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // normal END run with growing gaps: 21 RUN cycles
        drive(1'b1, 1'b0, 2'd0);
        expect_out("start", 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            idle(k);
            drive(1'b0, 1'b1, sts[k]);
        end
        expect_out("end", 3, 2, 0, 1, 1, 0);
        check("end.cycle", 32'(bus.o_cycle_cnt), cyc_exp(21));

        // OVERFLOW run, then a stray valid in DONE
        drive(1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 2'd1);
        drive(1'b0, 1'b1, 2'd2);
        expect_out("ovf", 0, 1, 0, 1, 2, 0);
        check("ovf.cycle", 32'(bus.o_cycle_cnt), cyc_exp(2));
        drive(1'b0, 1'b1, 2'd0);
        expect_out("ovf_err", 0, 1, 0, 1, 2, 1);

        // watchdog fires exactly 8 cycles after the last valid
        drive(1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 2'd0);
        idle(7);
        expect_out("wd_pre", 1, 0, 1, 0, 0, 0);
        idle(1);
        expect_out("wd_fire", 1, 0, 0, 1, 3, 0);
        check("wd.cycle", 32'(bus.o_cycle_cnt), cyc_exp(9));

        // valid on the expiry cycle wins and restarts the gap
        drive(1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 2'd0);
        idle(7);
        drive(1'b0, 1'b1, 2'd0);
        expect_out("wd_save", 2, 0, 1, 0, 0, 0);
        idle(7);
        check("wd_save2.busy", 32'(bus.o_busy), 1);
        idle(1);
        expect_out("wd_fire2", 2, 0, 0, 1, 3, 0);
        check("wd2.cycle", 32'(bus.o_cycle_cnt), cyc_exp(17));

        // saturation at 15
        drive(1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 2'd0);
        check("sat.r_pre", 32'(bus.o_r_cnt), 15);
        drive(1'b0, 1'b1, 2'd3);
        expect_out("sat", 15, 0, 0, 1, 1, 0);
        check("sat.cycle", 32'(bus.o_cycle_cnt), cyc_exp(21));

        // start beats a coincident valid and restarts the run
        drive(1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 2'd0);
        check("restart.r_pre", 32'(bus.o_r_cnt), 5);
        drive(1'b1, 1'b1, 2'd0);
        expect_out("restart", 0, 0, 1, 0, 0, 0);
        check("restart.cycle", 32'(bus.o_cycle_cnt), 0);

        // asynchronous reset between edges
        drive(1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 2'd1);
        expect_out("pre_rst", 0, 7, 1, 0, 0, 0);
        bus.i_status_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst.cycle", 32'(bus.o_cycle_cnt), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1'b0, 1'b1, 2'd0);
        expect_out("post_rst", 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
